// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART TX among NUM_REQ sources; a grant is held for the whole message. Build with UART_ARB_TAG_EN to prefix each message with tag byte 8'hA0|id.
// Latency: request seen in ARB -> req_ready next cycle; accepted byte -> tx_valid next cycle.
// Backpressure: tx_ready/enable stall SEND indefinitely; a granted source idle MAX_GAP cycles in LOAD loses its grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_GAP = 1024,
  parameter int ID_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_en,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 gap_abort
);

  localparam int GAP_W = (MAX_GAP > 2) ? $clog2(MAX_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {ARB, LOAD, SEND, TAG} state_t;
`else
  typedef enum logic [1:0] {ARB, LOAD, SEND} state_t;
`endif

  state_t            state, state_nxt;
  logic [ID_W-1:0]   grant_id_q, last_grant, arb_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [7:0]        buf_dat, gnt_dat;
  logic              buf_last, busy_q, gap_abort_q;
  logic              arb_hit, gnt_valid, gnt_last, accept;
  logic              do_grant, do_latch, do_done, do_abort;
  int                cand;

  // Rotating priority search starting just after the previous grant
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(last_grant) + 1 + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!arb_hit && cand == j && req_valid[j]) begin
          arb_hit = 1'b1;
          arb_idx = ID_W'(j);
        end
      end
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_dat   = 8'h00;
    gnt_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        gnt_valid = req_valid[i];
        gnt_dat   = req_data[8*i +: 8];
        gnt_last  = req_last[i];
      end
    end
  end

  assign accept = tx_valid & tx_ready & enable;

  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_latch  = 1'b0;
    do_done   = 1'b0;
    do_abort  = 1'b0;
    case (state)
      ARB: begin
        if (arb_hit) begin
          do_grant = 1'b1;
`ifdef UART_ARB_TAG_EN
          state_nxt = TAG;
`else
          state_nxt = LOAD;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        if (accept) state_nxt = LOAD;
      end
`endif
      LOAD: begin
        if (gnt_valid) begin
          do_latch  = 1'b1;
          state_nxt = SEND;
        end else if (gap_cnt == GAP_LAST) begin
          do_abort  = 1'b1;
          state_nxt = ARB;
        end
      end
      SEND: begin
        if (accept) begin
          if (buf_last) begin
            do_done   = 1'b1;
            state_nxt = ARB;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Gap counter only advances while waiting in LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id_q  <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      busy_q      <= 1'b0;
      gap_cnt     <= '0;
      buf_dat     <= 8'h00;
      buf_last    <= 1'b0;
      gap_abort_q <= 1'b0;
    end else begin
      gap_abort_q <= do_abort;
      if (do_grant) begin
        grant_id_q <= arb_idx;
        busy_q     <= 1'b1;
        gap_cnt    <= '0;
      end
      if (do_latch) begin
        buf_dat  <= gnt_dat;
        buf_last <= gnt_last;
        gap_cnt  <= '0;
      end else if (do_abort) begin
        gap_cnt <= '0;
      end else if (state == LOAD) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
      if (do_done || do_abort) begin
        busy_q     <= 1'b0;
        last_grant <= grant_id_q;
      end
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state)
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = buf_dat;
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA0 | 8'(grant_id_q);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (state == LOAD) && (grant_id_q == ID_W'(i));
  end

  assign tx_en     = enable;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign gap_abort = gap_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues and a fixed-timing transmitter model feed a byte scoreboard.
module tb_uart_tx_arbiter;
  localparam int NR = 4, MG = 16, IW = 3, FRAME = 5;

  logic            clk = 1'b0, reset = 1'b1, enable = 1'b1;
  logic [NR-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [8*NR-1:0] req_data = '0;
  logic            tx_en, tx_valid, tx_ready = 1'b1;
  logic [7:0]      tx_data;
  logic [IW-1:0]   grant_id;
  logic            busy, gap_abort;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_GAP(MG), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_en(tx_en), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .gap_abort(gap_abort)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic [IW-1:0] id; } exp_t;
  exp_t expq[$];

  logic [8:0] mem [NR][64];
  int wp [NR], rp [NR], hs_cnt [NR];
  int errors = 0, checks = 0;
  int n_acc = 0, n_abort = 0, cyc = 0, load3_cyc = 0;
  logic tx_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input int src, input logic [7:0] d, input logic l);
    mem[src][wp[src]] = {l, d};
    wp[src]++;
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.d  = d;
    e.id = id[IW-1:0];
    expq.push_back(e);
  endtask

  task automatic push_tag(input int id);
`ifdef UART_ARB_TAG_EN
    logic [7:0] t;
    t = 8'hA0 | 8'(id);
    push_exp(id, t);
`else
    if (id < 0) $display("bad id");
`endif
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) rp[i] = wp[i];
    expq.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (expq.size() == 0 && !busy && rp[0] == wp[0] && rp[1] == wp[1] &&
          rp[2] == wp[2] && rp[3] == wp[3]) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'b0, ok}, 1);
  endtask

  task automatic wait_acc(input string name, input int target);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (n_acc >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'b0, ok}, 1);
  endtask

  // Requester queues, transmitter model and output monitor share one loop
  initial begin
    logic acc, prev_r3, prev_abort;
    logic [NR-1:0] hs;
    int cnt;
    exp_t e;
    cnt = 0; prev_r3 = 1'b0; prev_abort = 1'b0;
    for (int i = 0; i < NR; i++) begin wp[i] = 0; rp[i] = 0; hs_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      acc = tx_valid & tx_ready & enable;
      hs  = req_ready & req_valid;
      for (int i = 0; i < NR; i++) if (hs[i]) hs_cnt[i]++;
      if (acc) begin
        n_acc++;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
        end else begin
          e = expq.pop_front();
          chk("tx_data", tx_data, e.d);
          chk("tx_grant", grant_id, e.id);
        end
      end
      if (req_ready != '0) chk("ready_onehot", $onehot(req_ready), 1);
      if (req_ready[3] && !prev_r3) load3_cyc = cyc;
      if (gap_abort) begin
        n_abort++;
        chk("abort_delay", cyc - load3_cyc, MG);
        chk("abort_width", prev_abort, 0);
      end
      prev_r3 = req_ready[3];
      prev_abort = gap_abort;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (hs[i] && rp[i] < wp[i]) rp[i]++;
      if (acc) cnt = FRAME;
      else if (cnt > 0) cnt--;
      tx_ready = (cnt == 0) && !tx_stall;
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = rp[i] < wp[i];
        req_data[8*i +: 8] = mem[i][rp[i]][7:0];
        req_last[i] = mem[i][rp[i]][8];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct { int src; logic [7:0] d; logic [7:0] exp_d; int exp_id; } vec_t;
  vec_t tbl [5];

  initial begin
    int a0, h0, ab0;
    logic ok;
    tbl[0] = '{0, 8'h55, 8'h55, 0};
    tbl[1] = '{3, 8'hFF, 8'hFF, 3};
    tbl[2] = '{1, 8'h00, 8'h00, 1};
    tbl[3] = '{2, 8'hA5, 8'hA5, 2};
    tbl[4] = '{0, 8'h80, 8'h80, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", gap_abort, 0);
    reset = 1'b0;

    // Single-byte messages, one requester at a time
    for (int v = 0; v < 5; v++) begin
      h0 = hs_cnt[tbl[v].src];
      push_tag(tbl[v].exp_id);
      push_exp(tbl[v].exp_id, tbl[v].exp_d);
      push_byte(tbl[v].src, tbl[v].d, 1'b1);
      wait_idle("tbl_idle", 200);
      chk("tbl_busy", busy, 0);
      chk("tbl_gid", grant_id, tbl[v].exp_id);
      chk("tbl_hs", hs_cnt[tbl[v].src] - h0, 1);
    end

    // Two 3-byte messages requested together: no interleave
    push_tag(1);
    push_exp(1, 8'h11); push_exp(1, 8'h12); push_exp(1, 8'h13);
    push_tag(2);
    push_exp(2, 8'h21); push_exp(2, 8'h22); push_exp(2, 8'h23);
    push_byte(1, 8'h11, 1'b0); push_byte(1, 8'h12, 1'b0); push_byte(1, 8'h13, 1'b1);
    push_byte(2, 8'h21, 1'b0); push_byte(2, 8'h22, 1'b0); push_byte(2, 8'h23, 1'b1);
    wait_idle("multi_idle", 400);

    // Fresh reset, then all requesters continuously busy: grants 0,1,2,3,0,1,2,3
    reset = 1'b1; flush();
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) begin
        push_tag(i);
        push_exp(i, 8'(8'h40 + 8 * r + i));
      end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push_byte(i, 8'(8'h40 + 8 * r + i), 1'b1);
    wait_idle("rr_idle", 600);

    // Requester 3 stalls after its first byte; requester 0 takes over after abort
    ab0 = n_abort;
    a0 = n_acc;
    push_tag(3);
    push_exp(3, 8'h30);
    push_byte(3, 8'h30, 1'b0);
`ifdef UART_ARB_TAG_EN
    wait_acc("gap_first", a0 + 2);
`else
    wait_acc("gap_first", a0 + 1);
`endif
    push_tag(0);
    push_exp(0, 8'h0A);
    push_byte(0, 8'h0A, 1'b1);
    wait_idle("gap_idle", 300);
    chk("gap_count", n_abort - ab0, 1);
    chk("gap_gid", grant_id, 0);

    // enable low in SEND holds the byte
    a0 = n_acc;
    push_tag(1);
    push_exp(1, 8'h7E);
`ifdef UART_ARB_TAG_EN
    push_byte(1, 8'h7E, 1'b1);
    wait_acc("en_tag", a0 + 1);
    tx_stall = 1'b1;
`else
    tx_stall = 1'b1;
    push_byte(1, 8'h7E, 1'b1);
`endif
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (tx_valid && tx_data == 8'h7E) begin ok = 1'b1; break; end
    end
    chk("en_reach_send", {31'b0, ok}, 1);
    enable = 1'b0;
    tx_stall = 1'b0;
    a0 = n_acc;
    repeat (20) @(posedge clk);
    #1;
    chk("en_txen", tx_en, 0);
    chk("en_hold_valid", tx_valid, 1);
    chk("en_hold_data", tx_data, 8'h7E);
    chk("en_no_accept", n_acc - a0, 0);
    enable = 1'b1;
    wait_idle("en_idle", 100);
    chk("en_txen_hi", tx_en, 1);

    // Reset mid-message drops it without replay
    a0 = n_acc;
    push_tag(2);
    push_exp(2, 8'h61); push_exp(2, 8'h62); push_exp(2, 8'h63);
    push_byte(2, 8'h61, 1'b0); push_byte(2, 8'h62, 1'b0); push_byte(2, 8'h63, 1'b1);
    wait_acc("mid_first", a0 + 1);
    reset = 1'b1; flush();
    @(posedge clk); #1;
    chk("mid_ready", req_ready, 0);
    chk("mid_valid", tx_valid, 0);
    chk("mid_data", tx_data, 0);
    chk("mid_gid", grant_id, 0);
    chk("mid_busy", busy, 0);
    chk("mid_abort", gap_abort, 0);
    reset = 1'b0;
    a0 = n_acc;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_no_replay", n_acc - a0, 0);
    chk("mid_idle_busy", busy, 0);
    chk("exp_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8-bit UART transmitter among NUM_REQ requesters using round-robin arbitration.
- A grant is held for a whole message: bytes up to and including the one marked last.
- The block drives the transmitter's en/valid/in inputs and watches its ready output.
- Sits between the host-side message sources and the UART TX serializer, all in the same clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_GAP, 1024, max clk cycles a granted requester may stall between bytes before its grant is revoked
ID_W, 3, width of grant_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  global transmit enable; forwarded to tx_en
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  marks final byte of message; qualified by req_valid
req_ready  output  NUM_REQ  per-requester byte accept; one-hot or zero
tx_en  output  1  to transmitter en
tx_valid  output  1  to transmitter valid
tx_data  output  8  to transmitter in
tx_ready  input  1  from transmitter ready
grant_id  output  ID_W  index of current/last granted requester
busy  output  1  high while a grant is held
gap_abort  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset: clk and reset as named; reset is synchronous and active-high. On reset: req_ready=0, tx_valid=0, tx_data=0, grant_id=0, busy=0, gap_abort=0, state=ARB, rr pointer set so requester 0 has highest priority. Reset mid-message drops the message; no byte is replayed.
- tx_en = enable, combinational.
- No combinational path tx_ready->tx_valid or req_valid->req_ready; both outputs are decoded from registered state only.
- State ARB:
  - Search req_valid starting at (last_grant+1) mod NUM_REQ.
  - On a hit: register grant_id, busy<=1, go to LOAD. ARB-to-LOAD latency is 1 cycle.
  - No requests: stay in ARB.
- State LOAD:
  - req_ready[grant_id]=1.
  - If req_valid[grant_id]: latch data and last into buf/buf_last, clear gap counter, go to SEND.
  - Otherwise: increment gap counter. At MAX_GAP-1: pulse gap_abort, busy<=0, last_grant<=grant_id, go to ARB.
- State SEND:
  - tx_valid=1, tx_data=buf.
  - Accept occurs in a cycle where tx_valid & tx_ready & enable.
  - On accept with buf_last=1: busy<=0, last_grant<=grant_id, go to ARB.
  - On accept with buf_last=0: go to LOAD.
  - While enable=0, hold SEND indefinitely. The gap counter does not run in SEND.
- The transmitter's ready drops the cycle after accept and stays low for the whole frame (~10 bit periods). The arbiter simply waits in LOAD/SEND.
- Requester payload is passed unmodified. Bytes go out in order; a message is never interleaved with another message.
- req_valid from non-granted requesters is ignored and not acknowledged.
- If a requester presents req_last on its only byte, that is a 1-byte message.
- Round-robin fairness: with all requesters continuously requesting, grants cycle 0,1,2,3,0,...
- Gap counter width: $clog2(MAX_GAP); saturating semantics are not required because abort occurs first.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- When defined: after ARB, a TAG state is inserted before LOAD.
  - TAG drives tx_valid=1, tx_data = 8'hA0 | grant_id (zero-extended).
  - On accept, go to LOAD.
  - The gap counter starts only in LOAD.
  - A message aborted by gap timeout after its tag still consumes the tag byte.
- When not defined: the TAG state and its logic do not exist; ARB goes directly to LOAD and the byte stream is payload only.

Test Plan:
- Reset, then req_valid=4'b0001 with data 8'h55, last=1, using a transmitter model with fixed ready timing -> tx_data=8'h55 accepted once, req_ready[0] pulsed once, busy returns to 0, grant_id=0.
- Requesters 1 and 2 each send 3-byte messages (8'h11,12,13 and 8'h21,22,23) requested in the same cycle -> TX sequence 11,12,13,21,22,23; no interleave.
- All 4 requesters continuously send 1-byte messages for 8 messages -> grant order 0,1,2,3,0,1,2,3.
- Requester 3 sends byte 8'h30 (last=0) then stalls; MAX_GAP=16 -> gap_abort pulses exactly 16 cycles after LOAD entry; the next grant goes to requester 0 if it is pending.
- enable=0 while in SEND with buf=8'h7E -> tx_valid stays 1 and no accept; raise enable -> 8'h7E is accepted. Reset asserted mid-message -> all outputs return to reset values the next cycle.
- With UART_ARB_TAG_EN, requester 2 sends 8'hC3, last=1 -> TX sequence 8'hA2, 8'hC3.
